// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock supervisor: pulses the PLL reset, qualifies a synchronized lock,
// and holds the downstream system reset until lock has been stable long enough.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES     = 64,
  parameter int unsigned LOCK_TIMEOUT   = 5000000,
  parameter int unsigned STABLE_CYCLES  = 50000,
  parameter int unsigned RELEASE_CYCLES = 1024
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  input  logic       reconfig_req,
  output logic       reconfig_ack,
  input  logic       clr_status,
  output logic       lock_lost,
  output logic [7:0] retries
);

  localparam logic [23:0] RST_LAST     = 24'(RST_CYCLES - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(LOCK_TIMEOUT - 1);
  localparam logic [23:0] STABLE_LAST  = 24'(STABLE_CYCLES - 1);
  localparam logic [23:0] RELEASE_LAST = 24'(RELEASE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_PLLRST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [1:0]  sync_q, sync_d;
  logic        pll_rst_q, pll_rst_d;
  logic        sys_rst_q, sys_rst_d;
  logic        ready_q, ready_d;
  logic        ack_q, ack_d;
  logic        lock_lost_q, lock_lost_d;
  logic [7:0]  retries_q, retries_d;
  logic        lock_s;
  logic        lost_set;
  logic        retry_inc;

  assign lock_s = sync_q[1];

  always_comb begin
    sync_d    = {sync_q[0], pll_locked};
    state_d   = state_q;
    cnt_d     = cnt_q + 24'd1;
    lost_set  = 1'b0;
    retry_inc = 1'b0;
    ack_d     = 1'b0;

    case (state_q)
      S_PLLRST: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock arriving on the timeout cycle still counts as a lock.
        if (lock_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = S_PLLRST;
          retry_inc = 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s)                      state_d = S_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST)    state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!lock_s) begin
          state_d  = S_PLLRST;
          lost_set = 1'b1;
        end else if (cnt_q == RELEASE_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Lock loss and a re-lock request can coincide; both take effect.
        if (!lock_s) begin
          state_d  = S_PLLRST;
          lost_set = 1'b1;
        end
        if (reconfig_req) begin
          state_d = S_PLLRST;
          ack_d   = 1'b1;
        end
      end
      default: state_d = S_PLLRST;
    endcase

    if (state_d != state_q) cnt_d = 24'd0;

    lock_lost_d = lock_lost_q;
    if (lost_set)        lock_lost_d = 1'b1;
    else if (clr_status) lock_lost_d = 1'b0;

    retries_d = retries_q;
    if (retry_inc)       retries_d = (retries_q == 8'hff) ? 8'hff : retries_q + 8'd1;
    else if (clr_status) retries_d = 8'd0;

    // Outputs are decoded from the next state so they change on the entry edge.
    pll_rst_d = (state_d == S_PLLRST);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= S_PLLRST;
      cnt_q       <= 24'd0;
      sync_q      <= 2'b00;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      ack_q       <= 1'b0;
      lock_lost_q <= 1'b0;
      retries_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= sync_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      ack_q       <= ack_d;
      lock_lost_q <= lock_lost_d;
      retries_q   <= retries_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign sys_rst      = sys_rst_q;
  assign ready        = ready_q;
  assign reconfig_ack = ack_q;
  assign lock_lost    = lock_lost_q;
  assign retries      = retries_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: a table of hold-and-check vectors for the
// lock/lose/re-lock flow, then per-cycle sequences for timeout, glitch, reconfig.
module tb_pll_lock_sequencer;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       reconfig_req = 1'b0;
  logic       clr_status = 1'b0;
  logic       pll_rst, sys_rst, ready, reconfig_ack, lock_lost;
  logic [7:0] retries;

  int n_vec = 0;
  int n_bad = 0;

  always #5 refclk = ~refclk;

  pll_lock_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .RELEASE_CYCLES(4)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready),
    .reconfig_req(reconfig_req), .reconfig_ack(reconfig_ack),
    .clr_status(clr_status), .lock_lost(lock_lost), .retries(retries)
  );

  // Observation word: {pll_rst, sys_rst, ready, ack, lock_lost, retries[7:0]}
  function automatic logic [12:0] mk(input logic pr, input logic sr, input logic rd,
                                     input logic ak, input logic ll, input int rt);
    return {pr, sr, rd, ak, ll, 8'(rt)};
  endfunction

  typedef struct {
    int          n;
    logic        rst;
    logic        lk;
    logic        req;
    logic        clr;
    logic [12:0] exp;
  } vec_t;

  function automatic vec_t mkv(input int n, input logic r, input logic lk,
                               input logic req, input logic clr, input logic [12:0] e);
    vec_t v;
    v.n = n; v.rst = r; v.lk = lk; v.req = req; v.clr = clr; v.exp = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  task automatic chk(input string nm, input int idx, input logic [12:0] exp);
    logic [12:0] got;
    got = {pll_rst, sys_rst, ready, reconfig_ack, lock_lost, retries};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got pr/sr/rd/ak/ll=%b retries=%0d, want %b retries=%0d",
               nm, idx, got[12:8], got[7:0], exp[12:8], exp[7:0]);
    end
  endtask

  task automatic do_reset(input logic lk);
    rst = 1'b1; pll_locked = lk; reconfig_req = 1'b0; clr_status = 1'b0;
    tick(); tick();
    chk("reset", 0, mk(1, 1, 0, 0, 0, 0));
    rst = 1'b0;
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = mkv(3,  1, 0, 0, 0, mk(1, 1, 0, 0, 0, 0));
    tbl[1]  = mkv(3,  0, 0, 0, 0, mk(1, 1, 0, 0, 0, 0));
    tbl[2]  = mkv(1,  0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0));
    tbl[3]  = mkv(9,  0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0));
    tbl[4]  = mkv(14, 0, 1, 0, 0, mk(0, 1, 0, 0, 0, 0));
    tbl[5]  = mkv(1,  0, 1, 0, 0, mk(0, 0, 1, 0, 0, 0));
    tbl[6]  = mkv(5,  0, 1, 0, 0, mk(0, 0, 1, 0, 0, 0));
    tbl[7]  = mkv(2,  0, 0, 0, 0, mk(0, 0, 1, 0, 0, 0));
    tbl[8]  = mkv(1,  0, 0, 0, 0, mk(1, 1, 0, 0, 1, 0));
    tbl[9]  = mkv(3,  0, 1, 0, 0, mk(1, 1, 0, 0, 1, 0));
    tbl[10] = mkv(1,  0, 1, 0, 0, mk(0, 1, 0, 0, 1, 0));
    tbl[11] = mkv(1,  0, 1, 0, 0, mk(0, 1, 0, 0, 1, 0));
    tbl[12] = mkv(11, 0, 1, 0, 0, mk(0, 1, 0, 0, 1, 0));
    tbl[13] = mkv(1,  0, 1, 0, 0, mk(0, 0, 1, 0, 1, 0));
    tbl[14] = mkv(1,  0, 1, 0, 1, mk(0, 0, 1, 0, 0, 0));
    tbl[15] = mkv(2,  0, 1, 0, 0, mk(0, 0, 1, 0, 0, 0));

    // Reset, first lock, release latency, lock loss in RUN, re-lock, status clear.
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; pll_locked = tbl[i].lk;
      reconfig_req = tbl[i].req; clr_status = tbl[i].clr;
      repeat (tbl[i].n) tick();
      chk("table", i, tbl[i].exp);
    end

    // Lock never arrives: 24-cycle retry period, retries saturate at 255, then clear.
    do_reset(1'b0);
    for (int k = 1; k <= 258 * 24; k++) begin
      tick();
      chk("timeout", k, mk((k % 24) < 4, 1, 0, 0, 0, (k / 24 > 255) ? 255 : k / 24));
    end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("retries_clr", 0, mk(1, 1, 0, 0, 0, 0));

    // One-cycle synchronized glitch at STABLE cnt=5 restarts qualification only.
    do_reset(1'b1);
    for (int k = 1; k <= 24; k++) begin
      pll_locked = (k != 9);
      tick();
      chk("glitch", k, mk(k < 4, k < 24, k >= 24, 0, 0, 0));
    end

    // Request held from WAIT_LOCK: acked only once RUN is reached, then one restart.
    do_reset(1'b1);
    for (int k = 1; k <= 45; k++) begin
      reconfig_req = (k >= 5 && k <= 18);
      tick();
      chk("reconfig", k, mk((k < 4) || (k >= 18 && k <= 21),
                            !((k == 17) || (k >= 35)), (k == 17) || (k >= 35),
                            k == 18, 0, 0));
    end

    // Lock drop and request in the same RUN cycle, with clear on the set cycle.
    pll_locked = 1'b0;
    tick();
    chk("simul", 0, mk(0, 0, 1, 0, 0, 0));
    tick();
    chk("simul", 1, mk(0, 0, 1, 0, 0, 0));
    reconfig_req = 1'b1; clr_status = 1'b1;
    tick();
    chk("simul", 2, mk(1, 1, 0, 1, 1, 0));
    reconfig_req = 1'b0; clr_status = 1'b0;
    tick();
    chk("simul", 3, mk(1, 1, 0, 0, 1, 0));

    // Mid-operation reset clears sticky status immediately.
    rst = 1'b1;
    tick();
    chk("abort", 0, mk(1, 1, 0, 0, 0, 0));
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
